// File: rtl/memory_block_if.sv
// Control/address side of the SRAM-style memory bus: byte address plus the
// active-low CS/WE/OE strobes. The bidirectional Data bus is a plain inout port on the memory.
interface memory_block_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] Address;
  logic              CS;
  logic              WE;
  logic              OE;

  modport master (output Address, output CS, output WE, output OE);
  modport slave  (input  Address, input  CS, input  WE, input  OE);
endinterface

// File: rtl/memory_block.sv
// Word-organised single-port SRAM: clocked writes, combinational reads onto a
// shared tri-state bus, and asynchronous clear of the whole array on reset.
module memory_block #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  memory_block_if.slave     bus,
  inout  wire  [DATA_W-1:0] Data
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr_lsb;

  // Byte offset is ignored; upper bits must be zero, so there is no aliasing.
  assign idx             = bus.Address[IDX_W+1:2];
  assign in_range        = (bus.Address[ADDR_W-1:IDX_W+2] == '0);
  assign unused_addr_lsb = ^bus.Address[1:0];

  // Strobes compare against explicit levels so X/Z never enables an access.
  assign wr_en = (bus.CS == 1'b0) && (bus.WE == 1'b0) && in_range;
  assign rd_en = (reset == 1'b0) && (bus.CS == 1'b0) && (bus.OE == 1'b0) && (bus.WE == 1'b1);

  // A write cycle (WE=0) never drives the bus, even with OE=0.
  assign Data = rd_en ? (in_range ? mem[idx] : '0) : 'z;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= Data;
    end
  end
endmodule

// File: tb/tb_memory_block.sv
// Bench for memory_block: directed vector table, hand-written bus/reset
// sequences and randomized traffic against an array-based word model.
module tb_memory_block;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [31:0] TOP = DEPTH * 4;

  logic clock;
  logic reset;
  logic tb_drv;
  logic [DATA_W-1:0] tb_data;
  tri0  [DATA_W-1:0] data_bus;

  int checks;
  int failures;

  logic [DATA_W-1:0] model [DEPTH];

  memory_block_if #(.ADDR_W(ADDR_W)) bus_if ();

  memory_block #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave),
    .Data  (data_bus)
  );

  assign data_bus = tb_drv ? tb_data : 'z;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    bit          cs_n;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr < TOP) return model[addr / 4];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One bus write cycle: set up after the falling edge, commit on the rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit cs_n);
    @(negedge clock);
    bus_if.Address = addr;
    bus_if.CS = cs_n;
    bus_if.WE = 1'b0;
    bus_if.OE = 1'b1;
    tb_drv = 1'b1;
    tb_data = data;
    @(posedge clock);
    if (!cs_n && addr < TOP) model[addr / 4] = data;
    #1;
    tb_drv = 1'b0;
    bus_if.CS = 1'b1;
    bus_if.WE = 1'b1;
  endtask

  task automatic read_now(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_if.Address = addr;
    bus_if.CS = 1'b0;
    bus_if.WE = 1'b1;
    bus_if.OE = 1'b0;
    tb_drv = 1'b0;
    #1;
    check(name, data_bus, exp);
  endtask

  task automatic idle_bus();
    bus_if.CS = 1'b1;
    bus_if.WE = 1'b1;
    bus_if.OE = 1'b1;
    tb_drv = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, a2;
    bit cs_n;
    checks = 0;
    failures = 0;
    tb_drv = 1'b0;
    tb_data = '0;
    bus_if.Address = '0;
    idle_bus();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state: array cleared
    @(negedge clock);
    read_now("reset_state_0x8", 32'h8, 32'h0);
    read_now("reset_state_0x0", 32'h0, 32'h0);
    idle_bus();

    vecs[0]  = '{1'b1, 1'b0, 32'h0,         32'h8C010004};
    vecs[1]  = '{1'b1, 1'b0, 32'h4,         32'h00221820};
    vecs[2]  = '{1'b1, 1'b0, 32'h8,         32'hAC030008};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'h8C010004};
    vecs[4]  = '{1'b0, 1'b0, 32'h4,         32'h00221820};
    vecs[5]  = '{1'b0, 1'b0, 32'h8,         32'hAC030008};
    vecs[6]  = '{1'b1, 1'b1, 32'h4,         32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 1'b0, 32'h4,         32'h00221820};
    vecs[8]  = '{1'b0, 1'b0, 32'h6,         32'h00221820};
    vecs[9]  = '{1'b1, 1'b0, TOP,           32'h12345678};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h8C010004};
    vecs[11] = '{1'b0, 1'b0, TOP,           32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'hFFFFFFFC,  32'h0};
    vecs[13] = '{1'b0, 1'b0, TOP + 32'h4,   32'h0};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].cs_n);
      end else begin
        @(negedge clock);
        read_now($sformatf("vec%0d_rd_%08h", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
        idle_bus();
      end
    end

    // Zero-latency reads: several addresses within one clock phase
    @(negedge clock);
    read_now("lat0_a0", 32'h0, 32'h8C010004);
    read_now("lat0_a8", 32'h8, 32'hAC030008);
    read_now("lat0_a4", 32'h4, 32'h00221820);
    idle_bus();

    // Bus release: memory must not drive when deselected, OE off, or writing
    @(negedge clock);
    bus_if.Address = 32'h4;
    bus_if.CS = 1'b1; bus_if.WE = 1'b1; bus_if.OE = 1'b0;
    #1 check("release_cs_high", data_bus, 32'h0);
    bus_if.CS = 1'b0; bus_if.OE = 1'b1;
    #1 check("release_oe_high", data_bus, 32'h0);
    bus_if.OE = 1'b0; bus_if.WE = 1'b0;
    #1 check("release_we_low", data_bus, 32'h0);
    idle_bus();

    // Contention: WE=0 and OE=0 together, bench owns the bus and the write lands
    @(negedge clock);
    bus_if.Address = 32'hC;
    bus_if.CS = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'b0;
    tb_drv = 1'b1; tb_data = 32'hCAFEBABE;
    #1 check("contention_bus", data_bus, 32'hCAFEBABE);
    @(posedge clock);
    model[3] = 32'hCAFEBABE;
    #1 idle_bus();
    @(negedge clock);
    read_now("contention_readback", 32'hC, 32'hCAFEBABE);
    idle_bus();

    // Randomized traffic against the word model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom();
      else a = $urandom_range(0, DEPTH * 4 + 63);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom();
        cs_n = ($urandom_range(0, 4) == 0);
        do_write(a, d, cs_n);
      end else begin
        @(negedge clock);
        read_now($sformatf("rand_rd_%08h", a), a, model_read(a));
        a2 = $urandom_range(0, DEPTH * 4 - 1);
        read_now($sformatf("rand_rd2_%08h", a2), a2, model_read(a2));
        idle_bus();
      end
    end

    // Asynchronous reset pulse between edges, observed before any clock edge
    do_write(32'h8, 32'hAC030008, 1'b0);
    @(negedge clock);
    read_now("pre_reset_0x8", 32'h8, 32'hAC030008);
    reset = 1'b1;
    #1 check("reset_bus_released", data_bus, 32'h0);
    reset = 1'b0;
    #1 check("async_clear_0x8", data_bus, 32'h0);
    model_clear();
    idle_bus();

    // Reset held across an edge with a write pending: the write is lost
    do_write(32'h10, 32'h11111111, 1'b0);
    do_write(32'h14, 32'h22222222, 1'b0);
    @(negedge clock);
    bus_if.Address = 32'h10;
    bus_if.CS = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'b1;
    tb_drv = 1'b1; tb_data = 32'h55AA55AA;
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    idle_bus();
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    read_now("midop_0x10", 32'h10, 32'h0);
    read_now("midop_0x14", 32'h14, 32'h0);
    read_now("midop_0xC", 32'hC, 32'h0);
    read_now("midop_0x0", 32'h0, 32'h0);
    idle_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
